// File: rtl/cache_controller_pkg.sv
// Shared widths, FSM state encodings and pin bit positions for the cache demonstrator.
package cache_controller_pkg;

    localparam int ADDR_W  = 4;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = 2;
    localparam int DATA_W  = 8;
    localparam int LINES   = 1 << INDEX_W;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_LOOKUP = 2'd1;
    localparam state_t S_MEM    = 2'd2;
    localparam state_t S_RESP   = 2'd3;

    localparam int UIO_WE_BIT   = 4;
    localparam int UIO_REQ_BIT  = 5;
    localparam int UIO_DONE_BIT = 6;
    localparam int UIO_HIT_BIT  = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'b1100_0000;

endpackage

// File: rtl/cache_backing_mem.sv
// 16x8 backing store: synchronous write, combinational read, asynchronous clear.
module cache_backing_mem
    import cache_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache in front of a 16-byte store,
// exposed on the ui/uo/uio pin wrapper. rst_n is an active-high asynchronous reset.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int MISS_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LAT = MISS_LAT[3:0];

    logic                           rst;
    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic                           we_q, we_d;
    logic [DATA_W-1:0]              wdata_q, wdata_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic                           hit_lk_q, hit_lk_d;
    logic [DATA_W-1:0]              rdata_q, rdata_d;
    logic [DATA_W-1:0]              uo_q, uo_d;
    logic                           hit_q, hit_d;
    logic                           done_q, done_d;
    logic [LINES-1:0]               valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]    tag_q, tag_d;
    logic [LINES-1:0][DATA_W-1:0]   data_q, data_d;

    logic [INDEX_W-1:0]             idx;
    logic [TAG_W-1:0]               tag;
    logic                           lookup_hit;
    logic                           mem_last;
    logic                           mem_we;
    logic [DATA_W-1:0]              mem_rdata;
    logic                           unused_ok;

    assign rst        = rst_n;
    assign idx        = addr_q[INDEX_W-1:0];
    assign tag        = addr_q[ADDR_W-1:INDEX_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign mem_last   = (state_q == S_MEM) && (cnt_q == 4'd1);
    assign mem_we     = mem_last && we_q;

    cache_backing_mem u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        hit_lk_d = hit_lk_q;
        rdata_d  = rdata_q;
        uo_d     = uo_q;
        hit_d    = hit_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (ena && uio_in[UIO_REQ_BIT]) begin
                    addr_d  = uio_in[ADDR_W-1:0];
                    we_d    = uio_in[UIO_WE_BIT];
                    wdata_d = ui_in;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_lk_d = lookup_hit;
                if (!we_q && lookup_hit) begin
                    rdata_d = data_q[idx];
                    state_d = S_RESP;
                end else begin
                    cnt_d   = LAT;
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (mem_last) begin
                    // Writes touch the line only when it already holds this address.
                    if (!we_q) begin
                        valid_d[idx] = 1'b1;
                        tag_d[idx]   = tag;
                        data_d[idx]  = mem_rdata;
                        rdata_d      = mem_rdata;
                    end else if (hit_lk_q) begin
                        data_d[idx]  = wdata_q;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                done_d  = 1'b1;
                hit_d   = hit_lk_q;
                if (!we_q) begin
                    uo_d = rdata_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            hit_lk_q <= 1'b0;
            rdata_q  <= '0;
            uo_q     <= '0;
            hit_q    <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            hit_lk_q <= hit_lk_d;
            rdata_q  <= rdata_d;
            uo_q     <= uo_d;
            hit_q    <= hit_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {hit_q, done_q, 6'b00_0000};
    assign uio_oe  = UIO_OE_VAL;

    assign unused_ok = &{1'b0, uio_in[7:6]};

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: latency, hit/miss, write-through and reset abort.
module tb_cache_controller;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    cache_controller #(.MISS_LAT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed pin fields must hold on every cycle, including during reset.
    always @(negedge clk) begin
        checks++;
        if (uio_oe !== 8'hC0 || uio_out[5:0] !== 6'd0) begin
            errors++;
            $display("FAIL pins: uio_oe=%h uio_out[5:0]=%h required C0/00", uio_oe, uio_out[5:0]);
        end
    end

    // Issues one request, waits for done, checks latency/hit/data and the one-cycle done pulse.
    task automatic issue(input string name, input logic [3:0] a, input logic w, input logic [7:0] d,
                         input bit drop_ena, input int exp_lat, input logic exp_hit,
                         input logic [7:0] exp_uo);
        int  lat;
        bit  got;
        @(negedge clk);
        uio_in = {2'b00, 1'b1, w, a};
        ui_in  = d;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        if (drop_ena) ena = 1'b0;
        lat = 0;
        got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[6] === 1'b1) begin
                got = 1;
                lat = i;
            end
        end
        checks++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got=%0d lat=%0d required %0d", name, got, lat, exp_lat);
        end
        checks++;
        if (uio_out[7] !== exp_hit) begin
            errors++;
            $display("FAIL %s hit: %b required %b", name, uio_out[7], exp_hit);
        end
        checks++;
        if (uo_out !== exp_uo) begin
            errors++;
            $display("FAIL %s uo_out: %h required %h", name, uo_out, exp_uo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (uio_out[6] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, uio_out[6]);
        end
        ena = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hC0) begin
            errors++;
            $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h required 00/00/C0", uo_out, uio_out, uio_oe);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_read_miss_hit();
        issue("rd5_miss", 4'd5, 1'b0, 8'h00, 0, 6, 1'b0, 8'h00);
        issue("rd5_hit",  4'd5, 1'b0, 8'h00, 0, 2, 1'b1, 8'h00);
    endtask

    task automatic test_write_hit();
        issue("wr5_A5",   4'd5, 1'b1, 8'hA5, 0, 6, 1'b1, 8'h00);
        issue("rd5_A5",   4'd5, 1'b0, 8'h00, 0, 2, 1'b1, 8'hA5);
    endtask

    task automatic test_write_no_allocate();
        issue("wr9_3C",   4'd9, 1'b1, 8'h3C, 0, 6, 1'b0, 8'hA5);
        issue("rd5_still_hit", 4'd5, 1'b0, 8'h00, 0, 2, 1'b1, 8'hA5);
        issue("rd9_miss", 4'd9, 1'b0, 8'h00, 0, 6, 1'b0, 8'h3C);
        issue("rd5_evicted", 4'd5, 1'b0, 8'h00, 0, 6, 1'b0, 8'hA5);
    endtask

    task automatic test_back_to_back();
        int  n1;
        int  n2;
        bit  got;
        @(negedge clk);
        uio_in = {2'b00, 1'b1, 1'b0, 4'd9};
        @(posedge clk);
        #1;
        uio_in = {2'b00, 1'b1, 1'b0, 4'd5};
        got = 0;
        n1  = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[6] === 1'b1) begin
                got = 1;
                n1  = i;
            end
        end
        checks++;
        if (!got || n1 != 6 || uo_out !== 8'h3C || uio_out[7] !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d uo_out=%h hit=%b required 6/3C/0", n1, uo_out, uio_out[7]);
        end
        got = 0;
        n2  = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[6] === 1'b1) begin
                got = 1;
                n2  = i;
            end
        end
        uio_in = 8'h00;
        checks++;
        if (!got || n2 != 7 || uo_out !== 8'hA5 || uio_out[7] !== 1'b0) begin
            errors++;
            $display("FAIL held_req: gap=%0d uo_out=%h hit=%b required 7/A5/0", n2, uo_out, uio_out[7]);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ena();
        int seen;
        @(negedge clk);
        ena    = 1'b0;
        uio_in = {2'b00, 1'b1, 1'b0, 4'd2};
        seen   = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[6] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL ena_low: done seen %0d times, required 0", seen);
        end
        @(negedge clk);
        uio_in = 8'h00;
        ena    = 1'b1;
        issue("rd2_ena_drop", 4'd2, 1'b0, 8'h00, 1, 6, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_access();
        int seen;
        @(negedge clk);
        uio_in = {2'b00, 1'b1, 1'b1, 4'd2};
        ui_in  = 8'h77;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: uio_out=%h uo_out=%h required 00/00", uio_out, uo_out);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[6] === 1'b1) seen++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[6] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort: done seen %0d times, required 0", seen);
        end
        issue("rd2_after_reset", 4'd2, 1'b0, 8'h00, 0, 6, 1'b0, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_write_no_allocate();
        test_back_to_back();
        test_ena();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Tiny-tapeout-style cache demonstrator: 4-line direct-mapped, 1-byte-line cache in front of an internal 16-byte backing store.
- Write-through, no-write-allocate.
- Backing-store access costs a fixed parameterised latency.
- Sits at chip top, behind the standard ui/uo/uio pin wrapper.

Parameters:
- MISS_LAT, 4, backing-store access latency in cycles (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: asynchronous, active-high; a 1 on this pin resets the block, despite the wrapper name.
- ena  in  1  design selected; new requests are accepted only when 1.
- ui_in  in  8  write data.
- uo_out  out  8  read data register.
- uio_in  in  8  [3:0] addr, [4] we (1=write), [5] req; [7:6] ignored.
- uio_out  out  8  [6] done, [7] hit; [5:0] driven 0.
- uio_oe  out  8  constant 8'b1100_0000.

Behaviour:
- Address split: index = addr[1:0], tag = addr[3:2].
- Per line state: valid, 2-bit tag, 8-bit data.
- Reset (asynchronous, active-high):
  - all valid bits cleared, backing store zeroed;
  - uo_out = 0x00, done = 0, hit = 0, FSM = IDLE.
- FSM states: IDLE, LOOKUP, MEM, RESP.
- IDLE: on a clk edge with req=1 and ena=1, capture addr, we and ui_in; go to LOOKUP. Otherwise stay.
- LOOKUP (1 cycle): hit = valid[index] && tag match; latch hit.
  - Read hit -> RESP.
  - Read miss or any write -> MEM, load counter with MISS_LAT.
- MEM: count down MISS_LAT cycles, then:
  - read: fill line (valid=1, tag, data = mem[addr]) and load rdata;
  - write: mem[addr] = wdata; if the access was a hit, also update line data; on a miss the line is untouched (no allocate).
  - Then go to RESP.
- RESP: done = 1 for exactly one cycle.
  - hit holds the lookup result.
  - uo_out holds read data: mem value for reads, unchanged for writes.
  - Return to IDLE.
- Latency from the accepting edge to the done-asserting edge:
  - read hit: 2 cycles;
  - read miss or write: 2 + MISS_LAT cycles.
- uo_out and hit hold their values until the next response; done is low outside RESP.
- req is level-sensitive. If it stays high, a new request is accepted on the first IDLE edge after RESP (back-to-back).
- req or ena changes while not IDLE are ignored; an in-flight access always completes even if ena drops.
- Conflict misses evict the resident line silently; no dirty state exists because the cache is write-through.
- Reset asserted mid-access aborts it immediately: no memory write, no done.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOOKUP, MEM, RESP);
  - INDEX_W=2, TAG_W=2, ADDR_W=4;
  - uio bit-position constants.
- One natural sub-module, cache_backing_mem: 16x8 register file with synchronous write, combinational read, asynchronous clear.
- FSM, tag array and pin mapping live in the top.

Test Plan:
- Reset, read addr 5 -> done 2+4=6 cycles after accept, hit=0, uo_out=0x00. Re-read 5 -> done after 2 cycles, hit=1, uo_out=0x00.
- Write 0xA5 to addr 5 while cached -> done after 6 cycles, hit=1. Read 5 -> 2-cycle hit, uo_out=0xA5.
- Write 0x3C to addr 9 (index 1, line holds tag of addr 5) -> hit=0, no allocate.
  - Read 5 -> still a hit, 0xA5.
  - Read 9 -> miss, 0x3C.
  - Read 5 -> miss (evicted), 0xA5.
- Hold req=1 with a new addr during LOOKUP/MEM -> ignored. After RESP, a held req is accepted on the next IDLE edge. With ena=0, req=1 -> never accepted, done stays 0.
- Assert reset during MEM of a write of 0x77 to addr 2 -> no done. Read 2 after reset -> miss, uo_out=0x00.
- Check uio_oe=0xC0 and uio_out[5:0]=0 at all times; done is high for exactly one cycle per request.
